// File: rtl/cacheline_mem_arbiter.sv
// rtl/cacheline_mem_arbiter.sv - I/D cache-line port arbiter onto one memory port
//
// Merges the I-cache refill stream and the D-cache refill/write-back stream
// onto a single cache-line memory port. Round-robin between the two sides,
// one outstanding transaction, registered responses, watchdog abort.
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   I_strobe_i, I_addr_i                  I-side read request
//   I_done_o, I_data_o                    I-side completion pulse / read line
//   D_strobe_i, D_addr_i, D_rw_i, D_data_i D-side request (rw 1 = write)
//   D_done_o, D_data_o                    D-side completion pulse / read line
//   M_strobe_o, M_addr_o, M_rw_o, M_data_o memory request (level until done)
//   M_done_i, M_data_i                    memory completion pulse / read line
//   timeout_o                             sticky watchdog flag
module cacheline_mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int CLSIZE         = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              I_strobe_i,
  input  logic [XLEN-1:0]   I_addr_i,
  output logic              I_done_o,
  output logic [CLSIZE-1:0] I_data_o,
  input  logic              D_strobe_i,
  input  logic [XLEN-1:0]   D_addr_i,
  input  logic              D_rw_i,
  input  logic [CLSIZE-1:0] D_data_i,
  output logic              D_done_o,
  output logic [CLSIZE-1:0] D_data_o,
  output logic              M_strobe_o,
  output logic [XLEN-1:0]   M_addr_o,
  output logic              M_rw_o,
  output logic [CLSIZE-1:0] M_data_o,
  input  logic              M_done_i,
  input  logic [CLSIZE-1:0] M_data_i,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              pend_i_q;
  logic              pend_d_q;
  logic [XLEN-1:0]   i_addr_q;
  logic [XLEN-1:0]   d_addr_q;
  logic              d_rw_q;
  logic [CLSIZE-1:0] d_data_q;
  logic              gnt_d_q;   // side in service while not IDLE (1 = D)
  logic              last_d_q;  // last granted side (1 = D)
  logic [31:0]       cnt_q;

  logic i_take;
  logic d_take;
  logic pick_d;
  logic timeout_hit;

  always_comb begin
    // A side holding a pending or in-service request ignores its strobe
    // until its done pulse has been delivered and the FSM is back in IDLE.
    i_take = I_strobe_i && !pend_i_q && !((state_q != ST_IDLE) && !gnt_d_q);
    d_take = D_strobe_i && !pend_d_q && !((state_q != ST_IDLE) && gnt_d_q);
    // D wins when it is alone, or when both wait and I went last.
    pick_d = pend_d_q && (!pend_i_q || !last_d_q);
    // Counter holds the number of BUSY cycles already elapsed; this edge
    // completes the TIMEOUT_CYCLES-th one.
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      pend_i_q   <= 1'b0;
      pend_d_q   <= 1'b0;
      i_addr_q   <= '0;
      d_addr_q   <= '0;
      d_rw_q     <= 1'b0;
      d_data_q   <= '0;
      gnt_d_q    <= 1'b0;
      last_d_q   <= 1'b1;
      cnt_q      <= '0;
      I_done_o   <= 1'b0;
      I_data_o   <= '0;
      D_done_o   <= 1'b0;
      D_data_o   <= '0;
      M_strobe_o <= 1'b0;
      M_addr_o   <= '0;
      M_rw_o     <= 1'b0;
      M_data_o   <= '0;
      timeout_o  <= 1'b0;
    end else begin
      I_done_o <= 1'b0;
      D_done_o <= 1'b0;

      if (i_take) begin
        pend_i_q <= 1'b1;
        i_addr_q <= I_addr_i;
      end
      if (d_take) begin
        pend_d_q <= 1'b1;
        d_addr_q <= D_addr_i;
        d_rw_q   <= D_rw_i;
        d_data_q <= D_data_i;
      end

      case (state_q)
        ST_IDLE: begin
          if (pend_i_q || pend_d_q) begin
            gnt_d_q    <= pick_d;
            last_d_q   <= pick_d;
            cnt_q      <= '0;
            M_strobe_o <= 1'b1;
            state_q    <= ST_BUSY;
            if (pick_d) begin
              pend_d_q <= 1'b0;
              M_addr_o <= d_addr_q;
              M_rw_o   <= d_rw_q;
              M_data_o <= d_data_q;
            end else begin
              pend_i_q <= 1'b0;
              M_addr_o <= i_addr_q;
              M_rw_o   <= 1'b0;
              M_data_o <= '0;
            end
          end
        end

        ST_BUSY: begin
          if (M_done_i) begin
            M_strobe_o <= 1'b0;
            state_q    <= ST_RESP;
            if (gnt_d_q) begin
              D_data_o <= M_data_i;
              D_done_o <= 1'b1;
            end else begin
              I_data_o <= M_data_i;
              I_done_o <= 1'b1;
            end
          end else if (timeout_hit) begin
            M_strobe_o <= 1'b0;
            timeout_o  <= 1'b1;
            state_q    <= ST_RESP;
            if (gnt_d_q) begin
              D_data_o <= '0;
              D_done_o <= 1'b1;
            end else begin
              I_data_o <= '0;
              I_done_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        // Done pulse is visible during this state; next edge frees the port.
        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// tb/tb_cacheline_mem_arbiter.sv - scoreboard bench for cacheline_mem_arbiter
module tb_cacheline_mem_arbiter;
  localparam int XLEN   = 32;
  localparam int CLSIZE = 128;
  localparam int TMO    = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              I_strobe_i = 1'b0;
  logic [XLEN-1:0]   I_addr_i = '0;
  logic              I_done_o;
  logic [CLSIZE-1:0] I_data_o;
  logic              D_strobe_i = 1'b0;
  logic [XLEN-1:0]   D_addr_i = '0;
  logic              D_rw_i = 1'b0;
  logic [CLSIZE-1:0] D_data_i = '0;
  logic              D_done_o;
  logic [CLSIZE-1:0] D_data_o;
  logic              M_strobe_o;
  logic [XLEN-1:0]   M_addr_o;
  logic              M_rw_o;
  logic [CLSIZE-1:0] M_data_o;
  logic              M_done_i = 1'b0;
  logic [CLSIZE-1:0] M_data_i = '0;
  logic              timeout_o;

  cacheline_mem_arbiter #(
    .XLEN(XLEN), .CLSIZE(CLSIZE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .I_strobe_i(I_strobe_i), .I_addr_i(I_addr_i), .I_done_o(I_done_o), .I_data_o(I_data_o),
    .D_strobe_i(D_strobe_i), .D_addr_i(D_addr_i), .D_rw_i(D_rw_i), .D_data_i(D_data_i),
    .D_done_o(D_done_o), .D_data_o(D_data_o),
    .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o), .M_rw_o(M_rw_o), .M_data_o(M_data_o),
    .M_done_i(M_done_i), .M_data_i(M_data_i), .timeout_o(timeout_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    bit                side;   // 1 = D
    logic [XLEN-1:0]   addr;
    bit                rw;
    logic [CLSIZE-1:0] data;
    int                gap;    // 0 none, 1 latency from issue, 2 gap from previous done
    int                issue;
  } req_t;

  typedef struct {
    bit                side;
    logic [CLSIZE-1:0] data;
  } rsp_t;

  req_t exp_m[$];
  rsp_t exp_d[$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int txn_cnt = 0;
  int last_done_cyc = 0;
  bit withhold = 1'b0;
  bit stray = 1'b0;
  bit mon_act = 1'b0;
  bit model_last_d = 1'b1;
  int force_lat = 0;
  bit force_data_en = 1'b0;
  logic [CLSIZE-1:0] force_data = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CLSIZE-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: each request becomes one memory transaction; the side
  // is remembered as last grant so a later simultaneous pair alternates.
  task automatic push_req(input bit side, input logic [XLEN-1:0] a, input bit rw,
                          input logic [CLSIZE-1:0] d, input int gap, input int issue);
    req_t r;
    r.side  = side;
    r.addr  = a;
    r.rw    = side ? rw : 1'b0;
    r.data  = side ? d : '0;
    r.gap   = gap;
    r.issue = issue;
    exp_m.push_back(r);
    model_last_d = side;
  endtask

  task automatic release_all();
    @(negedge clk_i);
    I_strobe_i = 1'b0;
    D_strobe_i = 1'b0;
    I_addr_i   = $urandom;
    D_addr_i   = $urandom;
    D_rw_i     = 1'($urandom_range(0, 1));
    D_data_i   = rand128();
  endtask

  task automatic issue_single(input bit side, input logic [XLEN-1:0] a, input bit rw,
                              input logic [CLSIZE-1:0] d, input int gap);
    if (side) begin
      D_strobe_i = 1'b1; D_addr_i = a; D_rw_i = rw; D_data_i = d;
    end else begin
      I_strobe_i = 1'b1; I_addr_i = a;
    end
    push_req(side, a, rw, d, gap, cyc);
    release_all();
  endtask

  task automatic issue_pair(input logic [XLEN-1:0] ia, input logic [XLEN-1:0] da,
                            input bit rw, input logic [CLSIZE-1:0] d);
    bit first_d;
    I_strobe_i = 1'b1; I_addr_i = ia;
    D_strobe_i = 1'b1; D_addr_i = da; D_rw_i = rw; D_data_i = d;
    first_d = !model_last_d;
    if (first_d) begin
      push_req(1'b1, da, rw, d, 1, cyc);
      push_req(1'b0, ia, 1'b0, '0, 2, cyc);
    end else begin
      push_req(1'b0, ia, 1'b0, '0, 1, cyc);
      push_req(1'b1, da, rw, d, 2, cyc);
    end
    release_all();
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (n < 300 && (exp_m.size() != 0 || exp_d.size() != 0 || M_strobe_o || mon_act)) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check("quiet_bound", 1, 0);
    repeat (2) @(negedge clk_i);
  endtask

  // Monitor + memory model: pops expected requests when M_strobe_o rises,
  // answers after a chosen latency, pops expected responses on done.
  initial begin
    req_t cur;
    rsp_t e;
    rsp_t r;
    int len = 0;
    int lat = 1;
    int exp_len = 0;
    logic [CLSIZE-1:0] rdata = '0;
    bit stab_bad = 1'b0;
    bit prev_done = 1'b0;
    cur.side = 1'b0; cur.addr = '0; cur.rw = 1'b0; cur.data = '0; cur.gap = 0; cur.issue = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_m.delete();
        exp_d.delete();
        mon_act   = 1'b0;
        M_done_i  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (I_done_o || D_done_o) begin
          done_cnt++;
          check("done_onehot", 128'(I_done_o & D_done_o), 128'(0));
          check("done_width", 128'(prev_done), 128'(0));
          if (exp_d.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_d.pop_front();
            check("done_side", 128'(D_done_o), 128'(e.side));
            check("done_data", e.side ? D_data_o : I_data_o, e.data);
          end
          last_done_cyc = cyc;
        end
        prev_done = I_done_o || D_done_o;

        if (M_strobe_o && !mon_act) begin
          mon_act  = 1'b1;
          len      = 0;
          stab_bad = 1'b0;
          txn_cnt++;
          if (exp_m.size() == 0) begin
            check("unexpected_req", 1, 0);
          end else begin
            cur = exp_m.pop_front();
            check("req_addr", 128'(M_addr_o), 128'(cur.addr));
            check("req_rw", 128'(M_rw_o), 128'(cur.rw));
            check("req_data", M_data_o, cur.data);
            if (cur.gap == 1) check("grant_latency", 128'(cyc), 128'(cur.issue + 2));
            if (cur.gap == 2) check("b2b_gap", 128'(cyc), 128'(last_done_cyc + 2));
          end
          lat   = (force_lat != 0) ? force_lat : $urandom_range(1, TMO - 1);
          rdata = force_data_en ? force_data : rand128();
          r.side = cur.side;
          r.data = withhold ? '0 : rdata;
          exp_d.push_back(r);
          exp_len = withhold ? TMO : lat;
        end

        if (mon_act && M_strobe_o) begin
          len++;
          if (M_addr_o !== cur.addr || M_rw_o !== cur.rw || M_data_o !== cur.data) stab_bad = 1'b1;
          M_done_i = !withhold && (len == lat);
          M_data_i = M_done_i ? rdata : rand128();
        end else if (mon_act) begin
          check("strobe_len", 128'(len), 128'(exp_len));
          check("req_stable", 128'(stab_bad), 128'(0));
          mon_act  = 1'b0;
          M_done_i = 1'b0;
        end else begin
          M_done_i = stray;
          M_data_i = rand128();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int t0;
    int d0;
    int mode;
    bit s;
    repeat (3) @(negedge clk_i);
    check("rst_m_strobe", 128'(M_strobe_o), 0);
    check("rst_m_bus", 128'({M_addr_o, M_rw_o}), 0);
    check("rst_m_data", M_data_o, 0);
    check("rst_done", 128'({I_done_o, D_done_o, timeout_o}), 0);
    check("rst_i_data", I_data_o, 0);
    check("rst_d_data", D_data_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Simultaneous pairs from reset: I, D, I, D.
    check("model_first_is_i", 128'(model_last_d), 128'(1));
    issue_pair(32'h8000_0100, 32'h8000_0200, 1'b0, rand128());
    wait_quiet();
    issue_pair(32'h8000_0300, 32'h8000_0400, 1'b1, rand128());
    wait_quiet();

    // Single I read, 5-cycle memory.
    force_lat = 5;
    force_data_en = 1'b1;
    force_data = 128'h0123456789ABCDEF0123456789ABCDEF;
    issue_single(1'b0, 32'h8000_0040, 1'b0, '0, 1);
    wait_quiet();
    force_data_en = 1'b0;

    // D write-back.
    force_lat = 4;
    issue_single(1'b1, 32'h8000_1000, 1'b1, {16{8'hA5}}, 1);
    wait_quiet();

    // Level strobe on I: one transaction until done, then a re-strobe.
    force_lat = 3;
    t0 = txn_cnt;
    I_strobe_i = 1'b1;
    I_addr_i = 32'h8000_2000;
    push_req(1'b0, 32'h8000_2000, 1'b0, '0, 1, cyc);
    s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (I_done_o) begin
        s = 1'b1;
        break;
      end
    end
    I_strobe_i = 1'b0;
    check("level_done_seen", 128'(s), 128'(1));
    wait_quiet();
    check("level_one_txn", 128'(txn_cnt - t0), 128'(1));
    issue_single(1'b0, 32'h8000_2040, 1'b0, '0, 1);
    wait_quiet();
    check("level_restrobe_txn", 128'(txn_cnt - t0), 128'(2));

    // Randomized mix.
    force_lat = 0;
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: issue_single(1'b0, $urandom, 1'b0, '0, 1);
        1: issue_single(1'b1, $urandom, 1'($urandom_range(0, 1)), rand128(), 1);
        2: issue_pair($urandom, $urandom, 1'($urandom_range(0, 1)), rand128());
        default: begin
          s = 1'($urandom_range(0, 1));
          issue_single(s, $urandom, 1'($urandom_range(0, 1)), rand128(), 1);
          @(negedge clk_i);
          issue_single(!s, $urandom, 1'($urandom_range(0, 1)), rand128(), 2);
        end
      endcase
      wait_quiet();
    end

    // Watchdog abort, then a stray memory done.
    check("timeout_clear_before", 128'(timeout_o), 128'(0));
    withhold = 1'b1;
    issue_single(1'b0, 32'h8000_3000, 1'b0, '0, 1);
    wait_quiet();
    withhold = 1'b0;
    check("timeout_set", 128'(timeout_o), 128'(1));
    d0 = done_cnt;
    stray = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    stray = 1'b0;
    repeat (4) @(negedge clk_i);
    check("stray_no_done", 128'(done_cnt), 128'(d0));
    check("timeout_sticky", 128'(timeout_o), 128'(1));

    // Asynchronous reset in the middle of BUSY.
    withhold = 1'b1;
    issue_single(1'b1, 32'h8000_4000, 1'b0, '0, 1);
    for (int i = 0; i < 20 && !M_strobe_o; i++) @(negedge clk_i);
    check("rst_test_busy", 128'(M_strobe_o), 128'(1));
    repeat (3) @(posedge clk_i);
    #3;
    d0 = done_cnt;
    rst_ni = 1'b0;
    #1;
    check("async_rst_strobe", 128'(M_strobe_o), 128'(0));
    check("async_rst_timeout", 128'(timeout_o), 128'(0));
    withhold = 1'b0;
    model_last_d = 1'b1;
    repeat (2) @(negedge clk_i);
    check("async_rst_done", 128'({I_done_o, D_done_o}), 128'(0));
    check("async_rst_d_data", D_data_o, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("async_rst_no_done", 128'(done_cnt), 128'(d0));
    force_lat = 5;
    issue_single(1'b1, 32'h8000_5000, 1'b0, '0, 1);
    wait_quiet();
    check("post_rst_done", 128'(done_cnt), 128'(d0 + 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
